// File: rtl/nibble_serial_addsub_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor: FSM state
// encodings and the default operand width.
`ifndef NIBBLE_SERIAL_ADDSUB_PKG_SV
`define NIBBLE_SERIAL_ADDSUB_PKG_SV

package nibble_serial_addsub_pkg;

    localparam int NSA_DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } nsa_state_e;

endpackage

`endif

// File: rtl/nibble_serial_addsub_cla_nibble_adder.sv
// Combinational 4-bit carry-lookahead adder slice. Exposes C3 and C4 so the
// caller can form signed overflow from the top slice.
module cla_nibble_adder (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       c3,
    output logic       c4
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    assign g_s = x & y;
    assign p_s = x ^ y;

    // Lookahead carries, each expanded directly from G/P and the carry in.
    assign c_s[0] = cin;
    assign c_s[1] = g_s[0] | (p_s[0] & c_s[0]);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_s[0]);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & c_s[0]);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_s[0]);

    assign sum = p_s ^ c_s[3:0];
    assign c3  = c_s[3];
    assign c4  = c_s[4];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Serial add/subtract that processes one 4-bit slice per cycle through a
// single lookahead slice adder, LSB slice first.
module nibble_serial_addsub
    import nibble_serial_addsub_pkg::*;
#(
    parameter  int WIDTH = NSA_DEFAULT_WIDTH,
    localparam int NIB   = WIDTH / 4,
    localparam int CW    = (NIB > 1) ? $clog2(NIB) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    nsa_state_e       state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] result_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             cout_r;
    logic             ovf_r;

    logic [CW+1:0]    base_s;
    logic [3:0]       a_nib_s;
    logic [3:0]       b_nib_s;
    logic [3:0]       sum_s;
    logic             c3_s;
    logic             c4_s;

    assign base_s  = {cnt_r, 2'b00};
    assign a_nib_s = a_r[base_s +: 4];
    assign b_nib_s = b_r[base_s +: 4];

    cla_nibble_adder u_cla (
        .x   (a_nib_s),
        .y   (b_nib_s),
        .cin (carry_r),
        .sum (sum_s),
        .c3  (c3_s),
        .c4  (c4_s)
    );

    // Control FSM plus operand, slice counter, carry and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
            cnt_r    <= '0;
            carry_r  <= 1'b0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry in.
                        a_r      <= a;
                        b_r      <= b ^ {WIDTH{op_sub}};
                        carry_r  <= op_sub;
                        cnt_r    <= '0;
                        result_r <= '0;
                        state_r  <= ST_BUSY;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    result_r[base_s +: 4] <= sum_s;
                    carry_r               <= c4_s;
                    cnt_r                 <= cnt_r + CW'(1);
                    if (cnt_r == LAST) begin
                        cout_r  <= c4_s;
                        ovf_r   <= c4_s ^ c3_s;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_r == ST_BUSY);
    assign done   = (state_r == ST_DONE);
    assign result = result_r;
    assign cout   = cout_r;
    assign ovf    = ovf_r;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench: the driver pushes model results per accepted start, a
// monitor pops and checks them at the cycle done must appear.
module tb_nibble_serial_addsub;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    exp_t sb[$];
    int   cycle    = 0;
    int   compared = 0;
    int   mism     = 0;
    bit   mon_en   = 1'b0;

    nibble_serial_addsub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mism++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference: full-width two's-complement arithmetic, no slicing.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input int acc);
        exp_t        e;
        logic [W:0]  w;
        if (!s) w = {1'b0, x} + {1'b0, y};
        else    w = {1'b0, x} - {1'b0, y};
        e.r   = w[W-1:0];
        e.c   = s ? ~w[W] : w[W];
        e.v   = s ? ((x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]))
                  : ((x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]));
        e.acc = acc;
        return e;
    endfunction

    // Monitor: checks busy/done every cycle and pops results at acceptance + NIB.
    always begin
        exp_t e;
        @(posedge clk);
        cycle++;
        #1;
        if (mon_en) begin
            if (sb.size() == 0) begin
                chk("idle_busy", {31'd0, busy}, 32'd0);
                chk("idle_done", {31'd0, done}, 32'd0);
            end else begin
                e = sb[0];
                if (cycle < e.acc + NIB) begin
                    chk("busy_window", {31'd0, busy}, 32'd1);
                    chk("no_early_done", {31'd0, done}, 32'd0);
                end else begin
                    chk("done_latency", {31'd0, done}, 32'd1);
                    chk("busy_at_done", {31'd0, busy}, 32'd0);
                    chk("result", {16'd0, result}, {16'd0, e.r});
                    chk("cout", {31'd0, cout}, {31'd0, e.c});
                    chk("ovf", {31'd0, ovf}, {31'd0, e.v});
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge right after acceptance.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic iop);
        int g = 0;
        while (busy && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (busy) chk("issue_timeout", {31'd0, busy}, 32'd0);
        a      = ia;
        b      = ib;
        op_sub = iop;
        start  = 1'b1;
        sb.push_back(model(ia, ib, iop, cycle + 1));
        @(negedge clk);
        start  = 1'b0;
        chk("clear_on_accept", {16'd0, result}, 32'd0);
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic directed(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic iop,
                            input logic [W-1:0] er, input logic ec, input logic ev);
        issue(ia, ib, iop);
        wait_done();
        chk("dir_result", {16'd0, result}, {16'd0, er});
        chk("dir_cout", {31'd0, cout}, {31'd0, ec});
        chk("dir_ovf", {31'd0, ovf}, {31'd0, ev});
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b1;
        op_sub = 1'b0;
        a      = 16'hFFFF;
        b      = 16'hFFFF;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst    = 1'b0;
        start  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        directed(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        // Back-to-back from DONE, with ignored start pulses during BUSY.
        issue(16'h0010, 16'h0020, 1'b0);
        a = 16'hAAAA; b = 16'h5555; op_sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("b2b_result", {16'd0, result}, 32'h0030);
        repeat (3) @(negedge clk);
        chk("hold_result", {16'd0, result}, 32'h0030);

        directed(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        @(negedge clk);
        chk("hold_cout", {31'd0, cout}, 32'd1);

        // Reset on the second BUSY cycle, with start also high.
        issue(16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", {16'd0, result}, 32'd0);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        chk("abort_ovf", {31'd0, ovf}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        directed(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            issue(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            a      = 16'($urandom);
            b      = 16'($urandom);
            op_sub = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            for (int g = 0; g < 20 && !done; g++) @(negedge clk);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (NIB + 3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule

// File: doc/nibble_serial_addsub.md
NIBBLE_SERIAL_ADDSUB -- requirements
Module: nibble_serial_addsub

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter NIB, default WIDTH/4, number of 4-bit slices processed; derived, not overridden.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-006 op_sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-007 a  input  WIDTH  operand A; sampled with start.
REQ-008 b  input  WIDTH  operand B; sampled with start.
REQ-009 busy  output  1  high while slices are being processed.
REQ-010 done  output  1  one-cycle completion strobe.
REQ-011 result  output  WIDTH  sum/difference; valid from done until the next accepted start.
REQ-012 cout  output  1  carry out of MSB slice (subtract: 1 = no borrow).
REQ-013 ovf  output  1  signed two's-complement overflow.

Function
REQ-014 FSM SHALL have states IDLE, BUSY, DONE.
REQ-015 IDLE: start=1 -> latch a, b XOR {WIDTH{op_sub}}, carry register <= op_sub, slice counter <= 0, go BUSY; else stay.
REQ-016 BUSY: each cycle, slice at counter index SHALL be summed via 4-bit lookahead (C1..C4 from G/P and carry register); sum nibble written into result at that index; carry register <= C4; counter += 1.
REQ-017 BUSY -> DONE on the cycle the slice at index NIB-1 is processed; cout <= that C4; ovf <= C4 XOR C3 of that slice.
REQ-018 DONE: done=1 for exactly one cycle; start=1 there SHALL be accepted as in IDLE (back-to-back ops, next state BUSY); else go IDLE.
REQ-019 Latency: start sampled at edge k -> busy=1 during edges k+1..k+NIB, done=1 in the cycle following edge k+NIB (NIB cycles after acceptance; 4 for WIDTH=16).
REQ-020 start while BUSY SHALL be ignored; operands and op_sub held internally, input changes during BUSY have no effect.
REQ-021 busy SHALL equal (state==BUSY); done SHALL equal (state==DONE); both registered-state decodes, no combinational path from start.
REQ-022 result, cout, ovf SHALL hold their last values in IDLE; result SHALL be cleared to 0 on acceptance of a new start.
REQ-023 Arithmetic modulo 2^WIDTH; no saturation.
REQ-024 Counter width SHALL be ceil(log2(NIB)); wrap-around never reached because exit occurs at NIB-1.

Reset
REQ-025 rst=1 at any edge SHALL force IDLE, busy=0, done=0, result=0, cout=0, ovf=0, counter=0, carry=0, overriding start in the same cycle.
REQ-026 rst mid-BUSY SHALL abort without asserting done; first start after rst deasserts is accepted normally.

Structure
REQ-027 State encodings (IDLE=0, BUSY=1, DONE=2) and default WIDTH SHALL live in a shared include header with include guard.
REQ-028 One sub-module, cla_nibble_adder: 4-bit operands + carry in -> 4-bit sum, C3, C4, purely combinational, reusing the existing PG/lookahead equations; instantiated once.
REQ-029 All sequential logic in nibble_serial_addsub; no latches, no multiple drivers.

Verification
REQ-030 Add: a=0x1234, b=0x4321, op_sub=0 -> done 4 cycles later, result=0x5555, cout=0, ovf=0.
REQ-031 Carry chain: a=0xFFFF, b=0x0001, add -> result=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> result=0x8000, ovf=1.
REQ-032 Subtract: a=0x0005, b=0x0007, op_sub=1 -> result=0xFFFE, cout=0 (borrow), ovf=0; a=0x8000, b=0x0001 -> result=0x7FFF, ovf=1.
REQ-033 Back-to-back: start held high in DONE with a=0x0010, b=0x0020 -> busy next cycle, second done 4 cycles later, result=0x0030; start pulses during BUSY -> no effect, exactly one done per accepted start.
REQ-034 Reset mid-op: rst asserted on 2nd BUSY cycle -> next cycle busy=0, done never pulses, result=0; new start completes correctly.
REQ-035 Random: 10k random a, b, op_sub vs reference model, checking result, cout, ovf and done latency of exactly 4.
